gen_w_sched: RTL
================

GEN_W_SCHED -- requirements
Module: gen_w_sched

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning schedule word width: 32 selects the SHA-256 schedule, 64 selects the SHA-512 schedule; other values are illegal.
REQ-002 SHALL have parameter ROUNDS, default (WORD_W==64 ? 80 : 64), meaning number of W words produced per block; legal range 16..80.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port local_go_sig  in  1  start request, level-sensitive.
REQ-006 SHALL have port pad_reg  in  16*WORD_W  padded message block; word 0 occupies the MSBs.
REQ-007 SHALL have port w_ready  in  1  consumer accepts the current W word.
REQ-008 SHALL have port w_valid  out  1  w_data and w_index hold a valid word.
REQ-009 SHALL have port w_data  out  WORD_W  schedule word W_t.
REQ-010 SHALL have port w_index  out  7  index t of w_data.
REQ-011 SHALL have port busy  out  1  high in LOAD, RUN and DONE.
REQ-012 SHALL have port done  out  1  high in DONE.

Function
REQ-013 SHALL implement the state machine IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-014 In IDLE, local_go_sig==1 SHALL cause a transition to LOAD; otherwise the block SHALL stay in IDLE.
REQ-015 LOAD SHALL capture pad_reg into a 16-entry circular window and SHALL last one cycle.
REQ-016 w_valid SHALL first assert two cycles after the edge on which local_go_sig is sampled high in IDLE, with w_index=0.
REQ-017 A handshake (w_valid & w_ready) SHALL advance t by one; the next word SHALL be valid on the following cycle, sustaining one word per cycle under constant w_ready.
REQ-018 While w_valid=1 and w_ready=0, w_data and w_index SHALL hold stable.
REQ-019 For t<16, W_t SHALL equal window word t.
REQ-020 For t>=16, W_t SHALL equal sig1(W_t-2)+W_t-7+sig0(W_t-15)+W_t-16, computed modulo 2^WORD_W, and W_t SHALL overwrite window slot t mod 16.
REQ-021 For WORD_W=32: sig0 SHALL be ROTR7^ROTR18^SHR3 and sig1 SHALL be ROTR17^ROTR19^SHR10.
REQ-022 For WORD_W=64: sig0 SHALL be ROTR1^ROTR8^SHR7 and sig1 SHALL be ROTR19^ROTR61^SHR6.
REQ-023 The handshake at t=ROUNDS-1 SHALL move the block to DONE, with w_valid=0 on the next cycle.
REQ-024 DONE SHALL hold done=1 while local_go_sig=1 and SHALL return to IDLE on the first cycle local_go_sig=0.
REQ-025 local_go_sig changes outside IDLE and DONE SHALL be ignored.
REQ-026 pad_reg changes after LOAD SHALL NOT affect the words produced.

Reset
REQ-027 reset SHALL force IDLE, t=0, w_valid=0, w_data=0, w_index=0, busy=0, done=0 and clear the window, on the next edge, from any state including mid-RUN.
REQ-028 reset SHALL take priority over every handshake and start event in the same cycle.

Configuration
REQ-029 GEN_W_SCHED_RANDOM_READ_EN defined SHALL add a ROUNDS-deep store of every emitted W_t plus ports w_reg_read (in, 1), w_reg_addr (in, 7), regop_w_reg_rdy (out, 1) and regop_w_reg_data (out, WORD_W).
REQ-030 With GEN_W_SCHED_RANDOM_READ_EN defined, regop_w_reg_data SHALL return store[w_reg_addr] two cycles after w_reg_read, and regop_w_reg_rdy SHALL be high from the first handshake until the block re-enters IDLE.
REQ-031 With GEN_W_SCHED_RANDOM_READ_EN defined, both added outputs SHALL reset to 0.
REQ-032 Without GEN_W_SCHED_RANDOM_READ_EN, these ports and the store SHALL be absent, and only the 16-entry window SHALL exist.

Structure
REQ-033 Package sha_pkg SHALL hold the state enum, the sigma rotate/shift constants per WORD_W, and the default-ROUNDS function.
REQ-034 A sub-module gen_w_sigma (parameter WORD_W; combinational sig0/sig1) SHALL be instantiated twice.

Verification
REQ-035 SHA-256 "abc" block (pad_reg word0=0x61626380, word15=0x00000018, others 0) with w_ready=1 SHALL produce W0=0x61626380, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, then done=1.
REQ-036 WORD_W=64 "abc" block SHALL produce W0=0x6162638000000000, W15=0x18, W16=0x6162638000000000, and w_index 0..79 in order.
REQ-037 A w_ready low for 3 cycles at t=20 SHALL hold w_data/w_index stable, and resuming SHALL produce the same sequence as the no-stall run.
REQ-038 reset asserted at t=40 SHALL give all outputs 0 and IDLE on the next cycle, and a new start SHALL produce W0 two cycles later.
REQ-039 local_go_sig held high through DONE SHALL keep done=1 with no restart; dropping it SHALL return the block to IDLE, and raising it again SHALL restart.
REQ-040 With GEN_W_SCHED_RANDOM_READ_EN defined, a read of address 17 after done SHALL return 0x000F0000 on the "abc" block.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-2 message schedule generator:
// FSM state encoding, sigma rotate/shift amounts and the default round count.
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // SHA-256 small sigmas
  localparam int S32_SIG0_A   = 7;
  localparam int S32_SIG0_B   = 18;
  localparam int S32_SIG0_SHR = 3;
  localparam int S32_SIG1_A   = 17;
  localparam int S32_SIG1_B   = 19;
  localparam int S32_SIG1_SHR = 10;

  // SHA-512 small sigmas
  localparam int S64_SIG0_A   = 1;
  localparam int S64_SIG0_B   = 8;
  localparam int S64_SIG0_SHR = 7;
  localparam int S64_SIG1_A   = 19;
  localparam int S64_SIG1_B   = 61;
  localparam int S64_SIG1_SHR = 6;

  function automatic int default_rounds(input int word_w);
    return (word_w == 64) ? 80 : 64;
  endfunction

endpackage

// File: rtl/gen_w_sigma.sv
// Combinational SHA-2 small sigma: UPPER=0 gives sig0, UPPER=1 gives sig1,
// with the rotate/shift amounts chosen by WORD_W (32 or 64).
module gen_w_sigma
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter bit UPPER  = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] sig
);

  localparam int ROT_A = (WORD_W == 64) ? (UPPER ? S64_SIG1_A   : S64_SIG0_A)
                                        : (UPPER ? S32_SIG1_A   : S32_SIG0_A);
  localparam int ROT_B = (WORD_W == 64) ? (UPPER ? S64_SIG1_B   : S64_SIG0_B)
                                        : (UPPER ? S32_SIG1_B   : S32_SIG0_B);
  localparam int SHR   = (WORD_W == 64) ? (UPPER ? S64_SIG1_SHR : S64_SIG0_SHR)
                                        : (UPPER ? S32_SIG1_SHR : S32_SIG0_SHR);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  assign sig = rotr(x, ROT_A) ^ rotr(x, ROT_B) ^ (x >> SHR);

endmodule

// File: rtl/gen_w_sched.sv
// SHA-2 message schedule generator: streams W_0..W_ROUNDS-1 over a valid/ready
// port from a 16-word circular window. GEN_W_SCHED_RANDOM_READ_EN adds a readable store of all words.
module gen_w_sched
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = default_rounds(WORD_W)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 local_go_sig,
  input  logic [16*WORD_W-1:0] pad_reg,
  input  logic                 w_ready,
  output logic                 w_valid,
  output logic [WORD_W-1:0]    w_data,
  output logic [6:0]           w_index,
  output logic                 busy,
  output logic                 done
`ifdef GEN_W_SCHED_RANDOM_READ_EN
  ,
  input  logic                 w_reg_read,
  input  logic [6:0]           w_reg_addr,
  output logic                 regop_w_reg_rdy,
  output logic [WORD_W-1:0]    regop_w_reg_data
`endif
);

  state_t state, next_state;

  logic [WORD_W-1:0] window [16];
  logic [6:0]        t;
  logic [6:0]        t_next;
  logic [3:0]        slot_n, slot_2, slot_7, slot_15;
  logic [WORD_W-1:0] sig0_out, sig1_out, next_w;
  logic              handshake, last_word;

  assign w_valid   = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign w_index   = t;
  assign handshake = w_valid & w_ready;
  assign last_word = (t == 7'(ROUNDS - 1));

  // Window slots of the taps for the word after the current one
  assign t_next  = t + 7'd1;
  assign slot_n  = t_next[3:0];
  assign slot_2  = slot_n - 4'd2;
  assign slot_7  = slot_n - 4'd7;
  assign slot_15 = slot_n - 4'd15;

  gen_w_sigma #(.WORD_W(WORD_W), .UPPER(1'b0)) u_sig0 (
    .x   (window[slot_15]),
    .sig (sig0_out)
  );

  gen_w_sigma #(.WORD_W(WORD_W), .UPPER(1'b1)) u_sig1 (
    .x   (window[slot_2]),
    .sig (sig1_out)
  );

  // Slot t_next mod 16 still holds W_(t_next-16) until it is overwritten
  always_comb begin
    next_w = window[slot_n];
    if (t_next >= 7'd16)
      next_w = sig1_out + window[slot_7] + sig0_out + window[slot_n];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (local_go_sig) next_state = LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (handshake && last_word) next_state = DONE;
      DONE:    if (!local_go_sig) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) window[i] <= '0;
      t      <= '0;
      w_data <= '0;
    end else if (state == LOAD) begin
      for (int i = 0; i < 16; i++) window[i] <= pad_reg[(15-i)*WORD_W +: WORD_W];
      t      <= '0;
      w_data <= pad_reg[16*WORD_W-1 -: WORD_W];
    end else if (handshake && !last_word) begin
      t      <= t_next;
      w_data <= next_w;
      if (t_next >= 7'd16) window[slot_n] <= next_w;
    end
  end

`ifdef GEN_W_SCHED_RANDOM_READ_EN
  localparam int AW = $clog2(ROUNDS);

  logic [WORD_W-1:0] store [ROUNDS];
  logic [WORD_W-1:0] rd_stage;
  logic              rd_pending;

  always_ff @(posedge clock) begin
    if (handshake) store[t[AW-1:0]] <= w_data;
  end

  // Two-stage read: array lookup, then output register
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pending       <= 1'b0;
      rd_stage         <= '0;
      regop_w_reg_data <= '0;
      regop_w_reg_rdy  <= 1'b0;
    end else begin
      rd_pending <= w_reg_read;
      if (w_reg_read)
        rd_stage <= (w_reg_addr < 7'(ROUNDS)) ? store[w_reg_addr[AW-1:0]] : '0;
      if (rd_pending)
        regop_w_reg_data <= rd_stage;
      if (next_state == IDLE)
        regop_w_reg_rdy <= 1'b0;
      else if (handshake)
        regop_w_reg_rdy <= 1'b1;
    end
  end
`else
  // Only the 16-entry window holds schedule state in this build.
`endif

endmodule
